// File: rtl/scan_ctrl.sv
// -----------------------------------------------------------------------------
// scan_ctrl
//
// Row-scan controller for the LED matrix display path. Feeds the j_col column
// driver: matrix_out drives j_col.input_matrix and count drives j_col.count.
//
// A bitmap arriving from game logic over a valid/ready handshake lands in a
// shadow buffer. It is copied into the active frame (matrix_out) only at a
// frame boundary, so a frame never tears mid-scan. Each row is lit for DWELL
// clocks. Every row is preceded by BLANK clocks with all rows off, which hides
// the one-clock output latency of j_col after count changes.
//
// Ports
//   clk          in   1          system clock, rising edge
//   rst_n        in   1          asynchronous active-low reset
//   enable       in   1          1 = scan running, 0 = display off
//   frame_in     in   PIXEL      new frame bitmap; row r is bits [r*COL +: COL]
//   frame_valid  in   1          frame_in valid
//   frame_ready  out  1          shadow buffer empty (combinational)
//   matrix_out   out  PIXEL      active frame
//   count        out  BIT_COUNT  current row index
//   row_en       out  ROW        one-hot row drive, 0 while blanking/idle
//   blank        out  1          1 while no row is driven
//   frame_start  out  1          one-cycle pulse when row 0 blanking begins
// -----------------------------------------------------------------------------
module scan_ctrl #(
    parameter int ROW       = 4,
    parameter int COL       = 4,
    parameter int PIXEL     = ROW * COL,
    parameter int BIT_COUNT = 2,
    parameter int DWELL     = 1000,
    parameter int BLANK     = 16,
    parameter int TMR_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [PIXEL-1:0]     frame_in,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic [PIXEL-1:0]     matrix_out,
    output logic [BIT_COUNT-1:0] count,
    output logic [ROW-1:0]       row_en,
    output logic                 blank,
    output logic                 frame_start
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0]     BLANK_LOAD = TMR_W'(BLANK - 1);
    localparam logic [TMR_W-1:0]     DWELL_LOAD = TMR_W'(DWELL - 1);
    localparam logic [BIT_COUNT-1:0] LAST_ROW   = BIT_COUNT'(ROW - 1);

    state_t               state_q,       state_d;
    logic [TMR_W-1:0]     timer_q,       timer_d;
    logic [BIT_COUNT-1:0] count_q,       count_d;
    logic [ROW-1:0]       row_en_q,      row_en_d;
    logic                 blank_q,       blank_d;
    logic                 frame_start_q, frame_start_d;
    logic [PIXEL-1:0]     matrix_q,      matrix_d;
    logic [PIXEL-1:0]     shadow_q,      shadow_d;
    logic                 shadow_full_q, shadow_full_d;

    logic swap;
    logic capture;

    // Ready is the only combinational output: the producer sees the buffer
    // free in the same cycle the swap empties it.
    assign frame_ready = ~shadow_full_q;
    assign capture     = frame_valid & ~shadow_full_q;

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        count_d       = count_q;
        row_en_d      = row_en_q;
        blank_d       = blank_q;
        frame_start_d = 1'b0;
        swap          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                row_en_d = '0;
                blank_d  = 1'b1;
                count_d  = '0;
                if (enable) begin
                    state_d       = ST_BLANK;
                    timer_d       = BLANK_LOAD;
                    frame_start_d = 1'b1;
                    swap          = shadow_full_q;
                end
            end

            ST_BLANK: begin
                if (!enable) begin
                    state_d  = ST_IDLE;
                    row_en_d = '0;
                    blank_d  = 1'b1;
                    count_d  = '0;
                    timer_d  = '0;
                end else if (timer_q == '0) begin
                    state_d  = ST_DRIVE;
                    row_en_d = ROW'(1) << count_q;
                    blank_d  = 1'b0;
                    timer_d  = DWELL_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_DRIVE: begin
                if (!enable) begin
                    state_d  = ST_IDLE;
                    row_en_d = '0;
                    blank_d  = 1'b1;
                    count_d  = '0;
                    timer_d  = '0;
                end else if (timer_q == '0) begin
                    // count only moves here, so j_col never sees a row index
                    // change while a row is lit.
                    state_d  = ST_BLANK;
                    row_en_d = '0;
                    blank_d  = 1'b1;
                    timer_d  = BLANK_LOAD;
                    if (count_q != LAST_ROW) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        count_d       = '0;
                        frame_start_d = 1'b1;
                        swap          = shadow_full_q;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                row_en_d = '0;
                blank_d  = 1'b1;
                count_d  = '0;
                timer_d  = '0;
            end
        endcase
    end

    // Double buffer. swap needs a full shadow and capture needs an empty one,
    // so the two never act on the same edge: a frame captured at a boundary
    // waits in the shadow for the following boundary.
    always_comb begin
        matrix_d      = matrix_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        if (swap) begin
            matrix_d      = shadow_q;
            shadow_full_d = 1'b0;
        end
        if (capture) begin
            shadow_d      = frame_in;
            shadow_full_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            count_q       <= '0;
            row_en_q      <= '0;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            matrix_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            count_q       <= count_d;
            row_en_q      <= row_en_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
            matrix_q      <= matrix_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
        end
    end

    assign matrix_out  = matrix_q;
    assign count       = count_q;
    assign row_en      = row_en_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_ctrl
//
// Directed bench for scan_ctrl with DWELL=8, BLANK=2 (row period 10 clks,
// frame period 40 clks). Outputs are sampled 1 ns after each rising edge.
// k counts rising edges from the edge that first sees enable=1 (k=0).
// Within a frame: k%10 in {0,1} is blanking, {2..9} lights row (k%40)/10.
// -----------------------------------------------------------------------------
module tb_scan_ctrl;

    localparam int ROW       = 4;
    localparam int COL       = 4;
    localparam int PIXEL     = ROW * COL;
    localparam int BIT_COUNT = 2;
    localparam int DWELL     = 8;
    localparam int BLANK     = 2;
    localparam int TMR_W     = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic [PIXEL-1:0]     frame_in;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [PIXEL-1:0]     matrix_out;
    logic [BIT_COUNT-1:0] count;
    logic [ROW-1:0]       row_en;
    logic                 blank;
    logic                 frame_start;

    int tests;
    int fails;
    int k;

    scan_ctrl #(
        .ROW       (ROW),
        .COL       (COL),
        .PIXEL     (PIXEL),
        .BIT_COUNT (BIT_COUNT),
        .DWELL     (DWELL),
        .BLANK     (BLANK),
        .TMR_W     (TMR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .matrix_out  (matrix_out),
        .count       (count),
        .row_en      (row_en),
        .blank       (blank),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic step_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        int ph;
        int rw;
        tests       = 0;
        fails       = 0;
        k           = -100;
        rst_n       = 1'b0;
        enable      = 1'b0;
        frame_in    = '0;
        frame_valid = 1'b0;

        // ---- Reset state ----
        #12;
        chk("rst_row_en", 32'(row_en), 32'h0);
        chk("rst_blank", 32'(blank), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_matrix", 32'(matrix_out), 32'h0);
        chk("rst_ready", 32'(frame_ready), 32'h1);
        chk("rst_fstart", 32'(frame_start), 32'h0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();
        chk("idle_blank", 32'(blank), 32'h1);
        chk("idle_row_en", 32'(row_en), 32'h0);
        chk("idle_fstart", 32'(frame_start), 32'h0);

        // ---- Scan timing over one full frame plus the next boundary ----
        enable = 1'b1;
        k = -1;
        for (int i = 0; i <= 40; i++) begin
            step();
            ph = k % 10;
            rw = (k % 40) / 10;
            chk("scan_count", 32'(count), 32'(rw));
            chk("scan_blank", 32'(blank), (ph < 2) ? 32'h1 : 32'h0);
            chk("scan_row_en", 32'(row_en), (ph < 2) ? 32'h0 : (32'h1 << rw));
            chk("scan_fstart", 32'(frame_start), (k % 40 == 0) ? 32'h1 : 32'h0);
            chk("scan_onehot", ($countones(row_en) <= 1) ? 32'h1 : 32'h0, 32'h1);
        end
        chk("scan_matrix", 32'(matrix_out), 32'h0);

        // ---- Load: one-clock valid during row 1 ----
        step_to(52);
        frame_in    = 16'hA5A5;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        chk("load_ready_low", 32'(frame_ready), 32'h0);
        chk("load_matrix_old", 32'(matrix_out), 32'h0);
        step_to(79);
        chk("load_matrix_before", 32'(matrix_out), 32'h0);
        chk("load_ready_before", 32'(frame_ready), 32'h0);
        step();
        chk("load_fstart", 32'(frame_start), 32'h1);
        chk("load_matrix_swap", 32'(matrix_out), 32'hA5A5);
        chk("load_ready_high", 32'(frame_ready), 32'h1);

        // ---- Backpressure: fill shadow, then hold a second frame ----
        step_to(85);
        frame_in    = 16'h1234;
        frame_valid = 1'b1;
        step();
        chk("bp_first_taken", 32'(frame_ready), 32'h0);
        frame_in = 16'h0F0F;
        step_to(100);
        chk("bp_held_ready", 32'(frame_ready), 32'h0);
        chk("bp_held_matrix", 32'(matrix_out), 32'hA5A5);
        step_to(120);
        chk("bp_swap_matrix", 32'(matrix_out), 32'h1234);
        chk("bp_swap_ready", 32'(frame_ready), 32'h1);
        step();
        chk("bp_accepted", 32'(frame_ready), 32'h0);
        frame_valid = 1'b0;
        step_to(159);
        chk("bp_pending", 32'(matrix_out), 32'h1234);
        step();
        chk("bp_displayed", 32'(matrix_out), 32'h0F0F);

        // ---- Disable while row 2 is lit ----
        step_to(185);
        chk("dis_row2_lit", 32'(row_en), 32'h4);
        chk("dis_count2", 32'(count), 32'h2);
        enable = 1'b0;
        step();
        chk("dis_row_en", 32'(row_en), 32'h0);
        chk("dis_blank", 32'(blank), 32'h1);
        chk("dis_count", 32'(count), 32'h0);
        step();
        step();
        chk("dis_idle_row_en", 32'(row_en), 32'h0);
        chk("dis_matrix_kept", 32'(matrix_out), 32'h0F0F);
        enable = 1'b1;
        k = -1;
        step();
        chk("reen_fstart", 32'(frame_start), 32'h1);
        chk("reen_blank0", 32'(blank), 32'h1);
        step();
        chk("reen_blank1", 32'(blank), 32'h1);
        chk("reen_row_en1", 32'(row_en), 32'h0);
        step();
        chk("reen_row0", 32'(row_en), 32'h1);
        chk("reen_count", 32'(count), 32'h0);

        // ---- Capture on the same edge as a boundary, shadow empty ----
        step_to(39);
        frame_in    = 16'hBEEF;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        chk("same_fstart", 32'(frame_start), 32'h1);
        chk("same_matrix", 32'(matrix_out), 32'h0F0F);
        chk("same_ready", 32'(frame_ready), 32'h0);
        step_to(79);
        chk("same_pending", 32'(matrix_out), 32'h0F0F);
        step();
        chk("same_displayed", 32'(matrix_out), 32'hBEEF);
        chk("same_ready_back", 32'(frame_ready), 32'h1);

        // ---- Asynchronous reset mid-DRIVE, no clock edge ----
        step_to(85);
        chk("mid_drive_lit", 32'(row_en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_row_en", 32'(row_en), 32'h0);
        chk("arst_blank", 32'(blank), 32'h1);
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_matrix", 32'(matrix_out), 32'h0);
        chk("arst_ready", 32'(frame_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
